i2c_bus_cond_detect: RTL and testbench
======================================

// Module: i2c_bus_cond_detect
// PURPOSE
// - Consumes the deglitched SCL_F/SDA_F from the I2C pad filter stage.
// - Synchronises both lines into CLK and detects START, repeated START and STOP.
// - Tracks bus-busy state and deserialises the 8 data bits plus the ACK slot of each byte.
// - Drives the I2C slave/master protocol FSM; all outputs are registered.
// PARAMETERS
// - SYNC_STAGES  2     flops per line in the synchroniser; legal range 2..4.
// - TOUT_CYC     4096  CLK cycles SCL may stay low while busy before TIMEOUT fires.
// - TOUT_W       13    counter width; must satisfy 2**TOUT_W > TOUT_CYC.
// PORTS
// - CLK        in   1  system clock; all state is on the rising edge.
// - RSTB       in   1  synchronous, active-low reset.
// - SCL_F      in   1  deglitched SCL; asynchronous to CLK.
// - SDA_F      in   1  deglitched SDA; asynchronous to CLK.
// - START      out  1  1-cycle pulse: START seen while the bus was idle.
// - RSTART     out  1  1-cycle pulse: START seen while BUS_BUSY=1.
// - STOP       out  1  1-cycle pulse: STOP condition seen.
// - BUS_BUSY   out  1  set on START/RSTART; cleared on STOP or TIMEOUT.
// - BYTE_VLD   out  1  1-cycle pulse: 8th bit sampled; BYTE_DATA is valid in the same cycle.
// - BYTE_DATA  out  8  assembled byte, MSB first; holds its value until the next BYTE_VLD.
// - ACK_VLD    out  1  1-cycle pulse: 9th (ACK) bit sampled.
// - ACK_VAL    out  1  1 = ACK (SDA sampled low); 0 = NACK; holds until next ACK_VLD.
// - TIMEOUT    out  1  1-cycle pulse: SCL-low time limit reached.
// BEHAVIOUR
// - Reset (RSTB=0 at a CLK edge): all outputs go to 0.
//   - Synchroniser flops and previous-value flops reset to 1 (idle-high bus), so no false edge after reset.
//   - FSM goes to IDLE; bit counter and timeout counter clear.
// - Synchronised signals: scl_s/sda_s = last synchroniser stage; scl_p/sda_p = their previous values.
// - Condition decode (requires scl_s=1 and scl_p=1):
//   - sda fall -> START, or RSTART if BUS_BUSY=1.
//   - sda rise -> STOP.
// - Simultaneous SCL and SDA change in the same cycle:
//   - Not a condition; only the SCL edge is processed.
//   - The SDA value used is sda_s of that cycle.
// - Latency: a condition pulse is asserted SYNC_STAGES+1 CLK cycles after the pin edge.
// - FSM states: IDLE, BITS, ACK.
//   - IDLE: SCL edges are ignored. START -> BITS with bitcnt=0.
//   - BITS: on each scl rise, shift sda_s into shreg and increment bitcnt.
//     At bitcnt=7 the shift completes the byte: pulse BYTE_VLD, load BYTE_DATA, go to ACK.
//   - ACK: on scl rise, pulse ACK_VLD, set ACK_VAL = ~sda_s, bitcnt=0, go to BITS.
// - STOP in any state -> IDLE; any partial byte is discarded with no BYTE_VLD.
// - RSTART in BITS or ACK -> BITS, bitcnt=0, shreg cleared, no BYTE_VLD.
// - Timeout: tcnt increments while BUS_BUSY=1 and scl_s=0; it clears when scl_s=1 or BUS_BUSY=0.
//   - At tcnt==TOUT_CYC-1: pulse TIMEOUT, BUS_BUSY<=0, FSM -> IDLE, tcnt<=0.
//   - The counter never wraps.
// - Priority within a single cycle: reset > STOP > START/RSTART > TIMEOUT > bit sampling.
// - Reset asserted mid-byte: the state is dropped; no pulses are emitted for partial data.
// STRUCTURE
// - Package i2c_mon_pkg holds:
//   - the state enum {IDLE, BITS, ACK};
//   - ACK_LVL = 1'b0;
//   - BYTE_BITS = 8.
// - Sub-module i2c_sync_edge: SYNC_STAGES-flop synchroniser with reset value 1, plus rise/fall outputs.
//   It is instantiated once for SCL and once for SDA.
// - The top level contains the condition decode, the FSM, the shift register, bitcnt and tcnt.
// TESTING
// - Reset release with SCL=SDA=1 for 20 cycles -> no pulses, BUS_BUSY=0.
// - START, 8'hA5 MSB first, ACK (SDA=0), STOP -> pulses and values in order:
//   - START;
//   - BYTE_VLD with BYTE_DATA=8'hA5;
//   - ACK_VLD with ACK_VAL=1;
//   - STOP, with BUS_BUSY=0 one cycle later.
// - START, 4 bits, RSTART, then 8'h3C and NACK -> RSTART pulse, one BYTE_VLD (8'h3C), ACK_VAL=0.
// - SCL and SDA driven low in the same CLK cycle while idle -> no START, BUS_BUSY stays 0.
// - START, then SCL held low for TOUT_CYC cycles -> one TIMEOUT pulse, BUS_BUSY=0, FSM IDLE.
// - RSTB=0 during bit 5 of a byte, then a clean frame with 8'h81 -> only 8'h81 is reported.

Source files
------------

// File: rtl/i2c_mon_pkg.sv
// Shared types and constants for the I2C bus condition monitor.
//   state_t   : byte-framing FSM states
//   ACK_LVL   : SDA level that signals ACK in the ninth bit slot
//   BYTE_BITS : data bits per byte
package i2c_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BITS,
    ACK
  } state_t;

  localparam logic        ACK_LVL   = 1'b0;
  localparam int unsigned BYTE_BITS = 8;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for one asynchronous bus line, with edge detect.
// All flops reset to 1 so an idle-high bus produces no edge after reset.
//   clk_i   : system clock
//   rstb_i  : synchronous active-low reset
//   d_i     : asynchronous line input
//   s_o     : synchronised line value (last stage)
//   rise_o  : s_o went 0->1 this cycle
//   fall_o  : s_o went 1->0 this cycle
module i2c_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstb_i,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i) begin
    if (!rstb_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/i2c_bus_cond_detect.sv
// I2C bus condition detector and byte deserialiser.
// Synchronises SCL/SDA, decodes START / repeated START / STOP, tracks bus
// busy with an SCL-low timeout, and frames 8 data bits plus the ACK slot.
//   CLK, RSTB          : clock, synchronous active-low reset
//   SCL_F, SDA_F       : deglitched bus lines (asynchronous)
//   START, RSTART, STOP: 1-cycle condition pulses
//   BUS_BUSY           : bus owned between START and STOP/TIMEOUT
//   BYTE_VLD, BYTE_DATA: byte complete pulse and held byte (MSB first)
//   ACK_VLD, ACK_VAL   : ACK slot pulse and held result (1 = ACK)
//   TIMEOUT            : 1-cycle pulse when SCL stays low too long
module i2c_bus_cond_detect
  import i2c_mon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TOUT_CYC    = 4096,
  parameter int unsigned TOUT_W      = 13
) (
  input  logic       CLK,
  input  logic       RSTB,
  input  logic       SCL_F,
  input  logic       SDA_F,
  output logic       START,
  output logic       RSTART,
  output logic       STOP,
  output logic       BUS_BUSY,
  output logic       BYTE_VLD,
  output logic [7:0] BYTE_DATA,
  output logic       ACK_VLD,
  output logic       ACK_VAL,
  output logic       TIMEOUT
);

  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TOUT_CYC - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(BYTE_BITS - 1);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk_i (CLK),
    .rstb_i(RSTB),
    .d_i   (SCL_F),
    .s_o   (scl_s),
    .rise_o(scl_rise),
    .fall_o(scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk_i (CLK),
    .rstb_i(RSTB),
    .d_i   (SDA_F),
    .s_o   (sda_s),
    .rise_o(sda_rise),
    .fall_o(sda_fall)
  );

  state_t            state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [TOUT_W-1:0] tcnt_q, tcnt_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d, rstart_q, rstart_d, stop_q, stop_d;
  logic              byte_vld_q, byte_vld_d, ack_vld_q, ack_vld_d;
  logic              ack_val_q, ack_val_d, timeout_q, timeout_d;
  logic [7:0]        byte_data_q, byte_data_d;

  // SCL steady high (no edge this cycle): an SDA edge that coincides with
  // an SCL edge is data movement, never a bus condition.
  logic scl_hold_hi, start_cond, stop_cond, tout_hit;
  assign scl_hold_hi = scl_s & ~(scl_rise | scl_fall);
  assign start_cond  = scl_hold_hi & sda_fall;
  assign stop_cond   = scl_hold_hi & sda_rise;
  assign tout_hit    = busy_q & ~scl_s & (tcnt_q == TOUT_LAST);

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    busy_d      = busy_q;
    byte_data_d = byte_data_q;
    ack_val_d   = ack_val_q;
    start_d     = 1'b0;
    rstart_d    = 1'b0;
    stop_d      = 1'b0;
    byte_vld_d  = 1'b0;
    ack_vld_d   = 1'b0;
    timeout_d   = 1'b0;

    if (!busy_q || scl_s || tout_hit) tcnt_d = '0;
    else                              tcnt_d = tcnt_q + TOUT_W'(1);

    if (stop_cond) begin
      stop_d   = 1'b1;
      busy_d   = 1'b0;
      state_d  = IDLE;
      bitcnt_d = '0;
      shreg_d  = '0;
    end else if (start_cond) begin
      if (busy_q) rstart_d = 1'b1;
      else        start_d  = 1'b1;
      busy_d   = 1'b1;
      state_d  = BITS;
      bitcnt_d = '0;
      shreg_d  = '0;
    end else if (tout_hit) begin
      timeout_d = 1'b1;
      busy_d    = 1'b0;
      state_d   = IDLE;
      bitcnt_d  = '0;
    end else if (scl_rise) begin
      unique case (state_q)
        IDLE: ;
        BITS: begin
          shreg_d = {shreg_q[6:0], sda_s};
          if (bitcnt_q == LAST_BIT) begin
            byte_vld_d  = 1'b1;
            byte_data_d = {shreg_q[6:0], sda_s};
            state_d     = ACK;
            bitcnt_d    = '0;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
        ACK: begin
          ack_vld_d = 1'b1;
          ack_val_d = (sda_s == ACK_LVL);
          state_d   = BITS;
          bitcnt_d  = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      tcnt_q      <= '0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      rstart_q    <= 1'b0;
      stop_q      <= 1'b0;
      byte_vld_q  <= 1'b0;
      byte_data_q <= '0;
      ack_vld_q   <= 1'b0;
      ack_val_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      tcnt_q      <= tcnt_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      rstart_q    <= rstart_d;
      stop_q      <= stop_d;
      byte_vld_q  <= byte_vld_d;
      byte_data_q <= byte_data_d;
      ack_vld_q   <= ack_vld_d;
      ack_val_q   <= ack_val_d;
      timeout_q   <= timeout_d;
    end
  end

  assign START     = start_q;
  assign RSTART    = rstart_q;
  assign STOP      = stop_q;
  assign BUS_BUSY  = busy_q;
  assign BYTE_VLD  = byte_vld_q;
  assign BYTE_DATA = byte_data_q;
  assign ACK_VLD   = ack_vld_q;
  assign ACK_VAL   = ack_val_q;
  assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_i2c_bus_cond_detect.sv
// Self-checking bench for i2c_bus_cond_detect. Bus transactions are driven
// at the pin level; a transaction-level model predicts the ordered list of
// reported events (START/RSTART/STOP/BYTE/ACK/TIMEOUT) which is compared
// against the events observed on the DUT outputs.
module tb_i2c_bus_cond_detect;

  localparam int SYNC   = 2;
  localparam int TOUT   = 4096;
  localparam int H      = 4;     // clocks between pin changes

  // event codes: kind*1000 + payload
  localparam int EV_START = 1000, EV_RSTART = 2000, EV_STOP = 3000;
  localparam int EV_BYTE  = 4000, EV_ACK    = 5000, EV_TOUT = 6000;

  logic       CLK = 1'b0;
  logic       RSTB = 1'b0;
  logic       SCL_F = 1'b1;
  logic       SDA_F = 1'b1;
  logic       START, RSTART, STOP, BUS_BUSY, BYTE_VLD, ACK_VLD, ACK_VAL, TIMEOUT;
  logic [7:0] BYTE_DATA;

  int tests = 0;
  int fails = 0;
  int obs_q[$];
  int exp_q[$];
  bit mon_en = 1'b0;
  bit model_busy = 1'b0;

  i2c_bus_cond_detect #(.SYNC_STAGES(SYNC), .TOUT_CYC(TOUT), .TOUT_W(13)) dut (
    .CLK(CLK), .RSTB(RSTB), .SCL_F(SCL_F), .SDA_F(SDA_F),
    .START(START), .RSTART(RSTART), .STOP(STOP), .BUS_BUSY(BUS_BUSY),
    .BYTE_VLD(BYTE_VLD), .BYTE_DATA(BYTE_DATA), .ACK_VLD(ACK_VLD),
    .ACK_VAL(ACK_VAL), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (START    === 1'b1) obs_q.push_back(EV_START);
      if (RSTART   === 1'b1) obs_q.push_back(EV_RSTART);
      if (STOP     === 1'b1) obs_q.push_back(EV_STOP);
      if (BYTE_VLD === 1'b1) obs_q.push_back(EV_BYTE + int'(BYTE_DATA));
      if (ACK_VLD  === 1'b1) obs_q.push_back(EV_ACK + int'(ACK_VAL));
      if (TIMEOUT  === 1'b1) obs_q.push_back(EV_TOUT);
    end
  end

  // ---------------- pin drivers + transaction model ----------------
  task automatic hold();
    repeat (H) @(negedge CLK);
  endtask

  task automatic m_start();
    exp_q.push_back(model_busy ? EV_RSTART : EV_START);
    model_busy = 1'b1;
  endtask

  task automatic drive_start();
    SDA_F = 1'b0; m_start(); hold();
    SCL_F = 1'b0; hold();
  endtask

  task automatic drive_bit(input logic b);
    SDA_F = b;    hold();
    SCL_F = 1'b1; hold();
    SCL_F = 1'b0; hold();
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic ack_bit);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
    exp_q.push_back(EV_BYTE + int'(d));
    drive_bit(ack_bit);
    exp_q.push_back(EV_ACK + ((ack_bit == 1'b0) ? 1 : 0));
  endtask

  task automatic drive_stop();
    SDA_F = 1'b0; hold();
    SCL_F = 1'b1; hold();
    SDA_F = 1'b1; exp_q.push_back(EV_STOP); model_busy = 1'b0; hold();
  endtask

  task automatic drive_rstart();
    SDA_F = 1'b1; hold();
    SCL_F = 1'b1; hold();
    SDA_F = 1'b0; m_start(); hold();
    SCL_F = 1'b0; hold();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RSTB = 1'b0;
    repeat (3) @(negedge CLK);
    tests++;
    if ({START, RSTART, STOP, BUS_BUSY, BYTE_VLD, ACK_VLD, ACK_VAL, TIMEOUT, BYTE_DATA} !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs got %b want all zero",
               {START, RSTART, STOP, BUS_BUSY, BYTE_VLD, ACK_VLD, ACK_VAL, TIMEOUT, BYTE_DATA});
    end
    RSTB = 1'b1;
    mon_en = 1'b1;
    obs_q.delete();
    repeat (20) @(negedge CLK);
    tests++;
    if (obs_q.size() != 0) begin
      fails++; $display("FAIL reset_idle_events got %0d events want 0", obs_q.size());
    end
    tests++;
    if (BUS_BUSY !== 1'b0) begin
      fails++; $display("FAIL reset_idle_busy got %b want 0", BUS_BUSY);
    end
  endtask

  task automatic test_frame();
    int lat;
    int stop_seen;
    obs_q.delete(); exp_q.delete();
    lat = 0;
    SDA_F = 1'b0; m_start();
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (START === 1'b1) begin lat = i; break; end
    end
    tests++;
    if (lat != SYNC + 1) begin
      fails++; $display("FAIL start_latency got %0d want %0d", lat, SYNC + 1);
    end
    hold();
    SCL_F = 1'b0; hold();
    drive_byte(8'hA5, 1'b0);
    SDA_F = 1'b0; hold();
    SCL_F = 1'b1; hold();
    SDA_F = 1'b1; exp_q.push_back(EV_STOP); model_busy = 1'b0;
    stop_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (STOP === 1'b1) begin stop_seen = 1; break; end
    end
    @(negedge CLK);
    tests++;
    if (stop_seen != 1 || BUS_BUSY !== 1'b0) begin
      fails++; $display("FAIL stop_busy stop_seen=%0d busy=%b want 1/0", stop_seen, BUS_BUSY);
    end
    repeat (10) @(negedge CLK);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL frame_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] != exp_q[i]) begin
        fails++; $display("FAIL frame_ev%0d got %0d want %0d", i, obs_q[i], exp_q[i]);
      end
    end
    tests++;
    if (BYTE_DATA !== 8'hA5 || ACK_VAL !== 1'b1) begin
      fails++; $display("FAIL frame_hold got %h/%b want a5/1", BYTE_DATA, ACK_VAL);
    end
  endtask

  task automatic test_rstart();
    obs_q.delete(); exp_q.delete();
    drive_start();
    for (int i = 0; i < 4; i++) drive_bit(1'($urandom_range(0, 1)));
    drive_rstart();
    drive_byte(8'h3C, 1'b1);
    drive_stop();
    repeat (10) @(negedge CLK);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL rstart_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] != exp_q[i]) begin
        fails++; $display("FAIL rstart_ev%0d got %0d want %0d", i, obs_q[i], exp_q[i]);
      end
    end
    tests++;
    if (BYTE_DATA !== 8'h3C || ACK_VAL !== 1'b0) begin
      fails++; $display("FAIL rstart_hold got %h/%b want 3c/0", BYTE_DATA, ACK_VAL);
    end
  endtask

  task automatic test_simultaneous();
    obs_q.delete();
    SCL_F = 1'b0; SDA_F = 1'b0;
    hold(); hold();
    tests++;
    if (BUS_BUSY !== 1'b0) begin
      fails++; $display("FAIL simul_busy got %b want 0", BUS_BUSY);
    end
    SCL_F = 1'b1; SDA_F = 1'b1;
    hold(); hold();
    tests++;
    if (obs_q.size() != 0) begin
      fails++; $display("FAIL simul_events got %0d want 0", obs_q.size());
    end
  endtask

  task automatic test_timeout();
    obs_q.delete(); exp_q.delete();
    drive_start();
    repeat (TOUT + 20) @(negedge CLK);
    exp_q.push_back(EV_TOUT); model_busy = 1'b0;
    tests++;
    if (BUS_BUSY !== 1'b0) begin
      fails++; $display("FAIL tout_busy got %b want 0", BUS_BUSY);
    end
    // clocking a full byte with no START must report nothing once idle
    SDA_F = 1'b1; hold();
    for (int i = 0; i < 9; i++) drive_bit(1'($urandom_range(0, 1)));
    SDA_F = 1'b1; hold();
    SCL_F = 1'b1; hold(); hold();
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL tout_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] != exp_q[i]) begin
        fails++; $display("FAIL tout_ev%0d got %0d want %0d", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midbyte();
    obs_q.delete(); exp_q.delete();
    drive_start();
    for (int i = 0; i < 5; i++) drive_bit(1'($urandom_range(0, 1)));
    SDA_F = 1'b1; hold();
    SCL_F = 1'b1; hold();
    RSTB = 1'b0;
    repeat (2) @(negedge CLK);
    tests++;
    if ({START, RSTART, STOP, BUS_BUSY, BYTE_VLD, ACK_VLD, TIMEOUT} !== 7'h0) begin
      fails++; $display("FAIL midrst_outputs got %b want 0",
                        {START, RSTART, STOP, BUS_BUSY, BYTE_VLD, ACK_VLD, TIMEOUT});
    end
    hold();
    RSTB = 1'b1; model_busy = 1'b0;
    hold();
    drive_start();
    drive_byte(8'h81, 1'b0);
    drive_stop();
    repeat (10) @(negedge CLK);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL midrst_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] != exp_q[i]) begin
        fails++; $display("FAIL midrst_ev%0d got %0d want %0d", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    obs_q.delete(); exp_q.delete();
    for (int f = 0; f < 5; f++) begin
      drive_start();
      for (int s = 0; s < int'($urandom_range(1, 3)); s++) begin
        case ($urandom_range(0, 3))
          0, 1: drive_byte(8'($urandom), 1'($urandom_range(0, 1)));
          2: begin
            // at most 6 bits: the SCL rise of the following condition adds one more
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) drive_bit(1'($urandom_range(0, 1)));
            drive_rstart();
          end
          default: drive_rstart();
        endcase
      end
      if ($urandom_range(0, 1) == 1)
        for (int k = 0; k < int'($urandom_range(1, 6)); k++) drive_bit(1'($urandom_range(0, 1)));
      drive_stop();
    end
    repeat (10) @(negedge CLK);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] != exp_q[i]) begin
        fails++; $display("FAIL rand_ev%0d got %0d want %0d", i, obs_q[i], exp_q[i]);
      end
    end
    tests++;
    if (BUS_BUSY !== 1'b0) begin
      fails++; $display("FAIL rand_busy got %b want 0", BUS_BUSY);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame();
    test_rstart();
    test_simultaneous();
    test_timeout();
    test_reset_midbyte();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
